// File: rtl/aligned_burst_read_master.sv
// Burst read master: issues aligned Avalon-MM read bursts into a show-ahead FIFO.
// Bursts never cross a MAXBURSTCOUNT-word boundary and never outrun FIFO space.
module aligned_burst_read_master #(
    parameter int DATAWIDTH       = 32,
    parameter int ADDRESSWIDTH    = 32,
    parameter int MAXBURSTCOUNT   = 4,
    parameter int BURSTCOUNTWIDTH = 3,
    parameter int FIFODEPTH       = 32,
    parameter int FIFODEPTH_LOG2  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_read_base,
    input  logic [ADDRESSWIDTH-1:0]    control_read_length,
    input  logic                       control_go,
    input  logic                       control_abort,
    output logic                       control_done,
    output logic                       control_early_done,
    input  logic                       user_read_buffer,
    output logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_data_available,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [DATAWIDTH/8-1:0]     master_byteenable,
    output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest
);

    localparam int BYTES = DATAWIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int PW    = FIFODEPTH_LOG2 + 1;
    localparam logic [ADDRESSWIDTH-1:0] MAXW = ADDRESSWIDTH'(MAXBURSTCOUNT);

    logic [ADDRESSWIDTH-1:0]    r_address;
    logic [ADDRESSWIDTH-1:0]    r_remaining;
    logic                       r_fixed;
    logic                       r_read;
    logic [BURSTCOUNTWIDTH-1:0] r_burst;
    logic                       r_abort_held;
    logic [PW-1:0]              r_pending;
    logic [PW-1:0]              r_used;
    logic [FIFODEPTH_LOG2-1:0]  r_wr_ptr;
    logic [FIFODEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DATAWIDTH-1:0]       r_mem [FIFODEPTH];

    logic                       w_accept;
    logic                       w_hold;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_go;
    logic                       w_early_done;
    logic                       w_done;
    logic [ADDRESSWIDTH-1:0]    w_addr_n;
    logic [ADDRESSWIDTH-1:0]    w_rem_n;
    logic                       w_fixed_n;
    logic [PW-1:0]              w_pend_n;
    logic [PW-1:0]              w_used_n;
    logic [ADDRESSWIDTH-1:0]    w_offset;
    logic [ADDRESSWIDTH-1:0]    w_limit;
    logic [ADDRESSWIDTH-1:0]    w_burst_wide;
    logic [BURSTCOUNTWIDTH-1:0] w_burst_n;
    logic [31:0]                w_free;
    logic                       w_issue;

    always_comb begin
        w_accept     = r_read && !master_waitrequest;
        w_hold       = r_read && master_waitrequest;
        w_push       = master_readdatavalid && (r_pending != '0);
        w_pop        = user_read_buffer && (r_used != '0);
        w_early_done = (r_remaining == '0) && !r_read;
        w_done       = w_early_done && (r_pending == '0) && (r_used == '0);
        w_go         = control_go && w_done;

        w_addr_n  = r_address;
        w_rem_n   = r_remaining;
        w_fixed_n = r_fixed;
        if (w_go) begin
            w_addr_n  = control_read_base;
            w_rem_n   = control_read_length >> SHIFT;
            w_fixed_n = control_fixed_location;
        end else if (w_accept) begin
            if (control_abort || r_abort_held)
                w_rem_n = '0;
            else
                w_rem_n = r_remaining - ADDRESSWIDTH'(r_burst);
            if (!r_fixed)
                w_addr_n = r_address + (ADDRESSWIDTH'(r_burst) << SHIFT);
        end else if (!r_read && control_abort) begin
            w_rem_n = '0;
        end

        w_pend_n = r_pending
                 + (w_accept ? PW'(r_burst) : '0)
                 - (w_push ? PW'(1) : '0);
        w_used_n = r_used + PW'(w_push) - PW'(w_pop);

        // The next command is sized from post-update state so bursts run back to back.
        w_offset     = (w_addr_n >> SHIFT) & (MAXW - 1'b1);
        w_limit      = w_fixed_n ? MAXW : (MAXW - w_offset);
        w_burst_wide = (w_rem_n < w_limit) ? w_rem_n : w_limit;
        w_burst_n    = BURSTCOUNTWIDTH'(w_burst_wide);
        w_free       = 32'(FIFODEPTH) - 32'(w_used_n) - 32'(w_pend_n);
        w_issue      = (w_rem_n != '0) && (w_free >= 32'(w_burst_n));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_address    <= '0;
            r_remaining  <= '0;
            r_fixed      <= 1'b0;
            r_read       <= 1'b0;
            r_burst      <= '0;
            r_abort_held <= 1'b0;
            r_pending    <= '0;
            r_used       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
        end else begin
            r_address   <= w_addr_n;
            r_remaining <= w_rem_n;
            r_fixed     <= w_fixed_n;
            r_pending   <= w_pend_n;
            r_used      <= w_used_n;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_hold) begin
                r_abort_held <= r_abort_held || control_abort;
            end else begin
                r_abort_held <= 1'b0;
                r_read       <= w_issue;
                r_burst      <= w_issue ? w_burst_n : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= master_readdata;
    end

    assign master_address      = r_address;
    assign master_read         = r_read;
    assign master_burstcount   = r_burst;
    assign master_byteenable   = '1;
    assign user_buffer_data    = r_mem[r_rd_ptr];
    assign user_data_available = (r_used != '0);
    assign control_early_done  = w_early_done;
    assign control_done        = w_done;

endmodule

// File: tb/tb_aligned_burst_read_master.sv
// Bench for aligned_burst_read_master: latency-3 slave model, command and data scoreboards.
module tb_aligned_burst_read_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        control_fixed_location;
    logic [31:0] control_read_base;
    logic [31:0] control_read_length;
    logic        control_go;
    logic        control_abort;
    logic        control_done;
    logic        control_early_done;
    logic        user_read_buffer;
    logic [31:0] user_buffer_data;
    logic        user_data_available;
    logic [31:0] master_address;
    logic        master_read;
    logic [3:0]  master_byteenable;
    logic [2:0]  master_burstcount;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_waitrequest;

    aligned_burst_read_master #(
        .DATAWIDTH(32), .ADDRESSWIDTH(32), .MAXBURSTCOUNT(4),
        .BURSTCOUNTWIDTH(3), .FIFODEPTH(8), .FIFODEPTH_LOG2(3)
    ) dut (
        .clk(clk), .reset(reset),
        .control_fixed_location(control_fixed_location),
        .control_read_base(control_read_base),
        .control_read_length(control_read_length),
        .control_go(control_go), .control_abort(control_abort),
        .control_done(control_done), .control_early_done(control_early_done),
        .user_read_buffer(user_read_buffer),
        .user_buffer_data(user_buffer_data),
        .user_data_available(user_data_available),
        .master_address(master_address), .master_read(master_read),
        .master_byteenable(master_byteenable),
        .master_burstcount(master_burstcount),
        .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .master_waitrequest(master_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; int due; int ep; } word_t;
    typedef struct { logic [31:0] a; logic [2:0] b; } cmd_t;

    word_t       rq[$];
    cmd_t        cmd_q[$];
    logic [31:0] exp_q[$];
    int npass = 0, ntot = 0;
    int epoch = 0, wait_left = 0, acc_cnt = 0, acc_words = 0, npop = 0;
    bit auto_pop = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Slave: waitrequest, command checking, in-order data return 3 cycles after acceptance.
    initial begin
        automatic int cyc = 0, last_due = 0, seq = 0;
        automatic bit held = 0;
        automatic logic [31:0] h_a;
        automatic logic [2:0] h_b;
        automatic word_t w;
        automatic cmd_t c;
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rq.size() != 0 && rq[0].due <= cyc) begin
                w = rq.pop_front();
                master_readdatavalid = 1'b1;
                master_readdata      = w.d;
                if (w.ep == epoch) exp_q.push_back(w.d);
            end else begin
                master_readdatavalid = 1'b0;
                master_readdata      = $urandom;
            end
            master_waitrequest = master_read && (wait_left > 0);
            if (master_read && !reset) begin
                if (held) begin
                    chk("hold_addr", master_address, h_a);
                    chk("hold_burst", master_burstcount, h_b);
                end else begin
                    held = 1; h_a = master_address; h_b = master_burstcount;
                end
                if (master_waitrequest) begin
                    wait_left--;
                end else begin
                    held = 0;
                    acc_cnt++;
                    acc_words += int'(master_burstcount);
                    if (cmd_q.size() == 0) begin
                        chk("cmd_unexpected", 1, 0);
                    end else begin
                        c = cmd_q.pop_front();
                        chk("cmd_addr", master_address, c.a);
                        chk("cmd_burst", master_burstcount, c.b);
                    end
                    for (int i = 0; i < int'(master_burstcount); i++) begin
                        w.d = 32'hC0DE_0000 + 32'(seq); seq++;
                        w.due = (cyc + 3 > last_due + 1) ? cyc + 3 : last_due + 1;
                        w.ep = epoch;
                        last_due = w.due;
                        rq.push_back(w);
                    end
                end
            end
        end
    end

    // User side: pops whenever allowed and checks each word against the scoreboard.
    initial begin
        user_read_buffer = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_pop && user_data_available && !reset) begin
                if (exp_q.size() == 0) chk("data_extra", 1, 0);
                else chk("data", user_buffer_data, exp_q.pop_front());
                user_read_buffer = 1'b1;
                npop++;
            end else begin
                user_read_buffer = 1'b0;
            end
        end
    end

    task automatic expect_cmd(input logic [31:0] a, input logic [2:0] b);
        cmd_t c;
        c.a = a; c.b = b;
        cmd_q.push_back(c);
    endtask

    task automatic go(input logic [31:0] base, input logic [31:0] len, input logic fx);
        npop = 0; acc_words = 0;
        control_read_base = base;
        control_read_length = len;
        control_fixed_location = fx;
        control_go = 1'b1;
        @(negedge clk);
        control_go = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 500 && !control_done; i++) @(negedge clk);
        chk({"done_", tag}, control_done, 1);
        chk({"cmds_left_", tag}, cmd_q.size(), 0);
        chk({"data_left_", tag}, exp_q.size(), 0);
    endtask

    initial begin
        int a0;
        reset = 1'b1;
        control_fixed_location = 0; control_read_base = 0; control_read_length = 0;
        control_go = 0; control_abort = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_read", master_read, 0);
        chk("rst_avail", user_data_available, 0);
        chk("rst_early", control_early_done, 1);
        chk("rst_done", control_done, 1);
        chk("rst_burst", master_burstcount, 0);
        chk("byteenable", master_byteenable, 4'hF);

        auto_pop = 1;
        for (int i = 0; i < 4; i++) expect_cmd(32'h100 + 32'(i * 16), 3'd4);
        go(32'h100, 64, 0);
        chk("busy", control_done, 0);
        wait_done("seq");
        chk("seq_pops", npop, 16);

        expect_cmd(32'h108, 3'd2); expect_cmd(32'h110, 3'd4); expect_cmd(32'h120, 3'd2);
        go(32'h108, 32, 0);
        wait_done("align");
        chk("align_pops", npop, 8);

        wait_left = 5; a0 = acc_cnt;
        expect_cmd(32'h200, 3'd4);
        go(32'h200, 16, 0);
        wait_done("wait");
        chk("wait_accepts", acc_cnt - a0, 1);
        chk("wait_left", wait_left, 0);

        expect_cmd(32'h40, 3'd4); expect_cmd(32'h40, 3'd2);
        go(32'h40, 24, 1);
        wait_done("fixed");
        chk("fixed_pops", npop, 6);

        auto_pop = 0;
        for (int i = 0; i < 4; i++) expect_cmd(32'h300 + 32'(i * 16), 3'd4);
        go(32'h300, 64, 0);
        repeat (40) @(negedge clk);
        chk("full_words", acc_words, 8);
        chk("full_read", master_read, 0);
        chk("full_avail", user_data_available, 1);
        chk("full_early", control_early_done, 0);
        auto_pop = 1;
        wait_done("full");
        chk("full_pops", npop, 16);

        expect_cmd(32'h400, 3'd4);
        go(32'h400, 64, 0);
        for (int i = 0; i < 20 && !master_read; i++) @(negedge clk);
        chk("abort_seen_read", master_read, 1);
        control_abort = 1'b1;
        @(negedge clk);
        control_abort = 1'b0;
        wait_done("abort");
        chk("abort_words", acc_words, 4);
        chk("abort_pops", npop, 4);

        auto_pop = 0;
        expect_cmd(32'h600, 3'd4); expect_cmd(32'h610, 3'd4);
        go(32'h600, 64, 0);
        repeat (40) @(negedge clk);
        control_abort = 1'b1;
        @(negedge clk);
        control_abort = 1'b0;
        chk("idle_abort_early", control_early_done, 1);
        auto_pop = 1;
        wait_done("idle_abort");
        chk("idle_abort_pops", npop, 8);

        a0 = acc_cnt;
        go(32'h700, 3, 0);
        chk("short_done", control_done, 1);
        repeat (5) @(negedge clk);
        chk("short_read", master_read, 0);
        chk("short_accepts", acc_cnt - a0, 0);

        auto_pop = 0; a0 = acc_cnt;
        expect_cmd(32'h500, 3'd4); expect_cmd(32'h510, 3'd4);
        go(32'h500, 64, 0);
        for (int i = 0; i < 20 && acc_cnt == a0; i++) @(negedge clk);
        chk("rst_mid_started", acc_cnt != a0, 1);
        @(posedge clk);
        #2;
        reset = 1'b1; epoch++;
        exp_q.delete(); cmd_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_mid_avail", user_data_available, 0);
        chk("rst_mid_done", control_done, 1);
        chk("rst_mid_read", master_read, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
